// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes 64-bit MCU command frames, executes them against the
// LED register and a bank of NUM_REGS 32-bit control registers, and returns a
// 64-bit response frame through a valid/ready handshake.
// Optional build macro: SPI_CMD_CTRL_CHECKSUM_EN enables check-byte validation.
module spi_cmd_ctrl #(
  parameter int         NUM_REGS  = 4,
  parameter logic [7:0] LED_RESET = 8'h00
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [63:0]              RX_DATA,
  input  logic                     RX_VLD,
  output logic [63:0]              TX_DATA,
  output logic                     TX_VLD,
  input  logic                     TX_RDY,
  output logic [7:0]               LED,
  output logic [NUM_REGS*32-1:0]   REGS,
  output logic                     BUSY,
  output logic                     OVERRUN
);

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_LED_WR   = 8'h01;
  localparam logic [7:0] OP_REG_WR   = 8'h02;
  localparam logic [7:0] OP_REG_RD   = 8'h03;
  localparam logic [7:0] OP_STAT_RD  = 8'h04;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_OP   = 8'hE0;
  localparam logic [7:0] ST_BAD_ADDR = 8'hE1;
  localparam logic [7:0] ST_BAD_CHK  = 8'hE2;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RESP} state_t;

  state_t                     state;
  logic [63:0]                frame;
  logic [7:0]                 status;
  logic [7:0]                 seq;
  logic [NUM_REGS-1:0][31:0]  regs;

  logic [7:0]                 op;
  logic [7:0]                 addr;
  logic [31:0]                data;
  logic                       addr_ok;
  logic [31:0]                rd_data;
  logic [7:0]                 status_c;
  logic [31:0]                resp_data;

  assign op   = frame[63:56];
  assign addr = frame[55:48];
  assign data = frame[31:0];

  assign REGS = regs;
  assign BUSY = (state != S_IDLE);

  // Address range check and read mux; address compared in full 8 bits so
  // out-of-range addresses never alias onto a real register.
  always_comb begin
    addr_ok = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == 8'(i)) begin
        addr_ok = 1'b1;
        rd_data = regs[i];
      end
    end
  end

`ifdef SPI_CMD_CTRL_CHECKSUM_EN
  logic [7:0] chk_calc;
  assign chk_calc = frame[63:56] ^ frame[55:48] ^ frame[39:32] ^ frame[31:24] ^
                    frame[23:16] ^ frame[15:8]  ^ frame[7:0];
`else
  // Check byte is don't-care in this build.
  logic unused_chk;
  assign unused_chk = ^frame[47:40];
`endif

  // Status decode in priority order: check byte, opcode, then address.
  always_comb begin
    status_c = ST_OK;
`ifdef SPI_CMD_CTRL_CHECKSUM_EN
    if (frame[47:40] != chk_calc)
      status_c = ST_BAD_CHK;
    else
`endif
    if (op > OP_STAT_RD)
      status_c = ST_BAD_OP;
    else if ((op == OP_REG_WR || op == OP_REG_RD) && !addr_ok)
      status_c = ST_BAD_ADDR;
  end

  // Response payload; errors and NOP return zero.
  always_comb begin
    resp_data = '0;
    if (status == ST_OK) begin
      case (op)
        OP_LED_WR, OP_REG_WR: resp_data = data;
        OP_REG_RD:            resp_data = rd_data;
        OP_STAT_RD:           resp_data = {31'h0, OVERRUN};
        default:              resp_data = '0;
      endcase
    end
  end

  // Command FSM: capture, decode, execute, then hold the response until taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      frame   <= '0;
      status  <= ST_OK;
      seq     <= '0;
      TX_DATA <= '0;
      TX_VLD  <= 1'b0;
      LED     <= LED_RESET;
      regs    <= '0;
      OVERRUN <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (RX_VLD) begin
            frame <= RX_DATA;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          status <= status_c;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          seq     <= seq + 8'd1;
          TX_DATA <= {op, addr, status, seq + 8'd1, resp_data};
          TX_VLD  <= 1'b1;
          state   <= S_RESP;
          if (status == ST_OK) begin
            case (op)
              OP_LED_WR:  LED <= data[7:0];
              OP_REG_WR: begin
                for (int i = 0; i < NUM_REGS; i++)
                  if (addr == 8'(i)) regs[i] <= data;
              end
              OP_STAT_RD: OVERRUN <= 1'b0;
              default: ;
            endcase
          end
        end
        S_RESP: begin
          if (TX_RDY) begin
            TX_VLD <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A frame arriving while busy is dropped; the late assignment lets a
      // fresh overrun win over a STAT_RD clear in the same cycle.
      if (RX_VLD && state != S_IDLE) OVERRUN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: a behavioural model predicts each response
// frame and the architectural state; a monitor compares responses on handshake.
module tb_spi_cmd_ctrl;

  localparam int         NUM_REGS  = 4;
  localparam logic [7:0] LED_RESET = 8'h3C;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b1;
  logic [63:0]             RX_DATA = '0;
  logic                    RX_VLD = 1'b0;
  logic [63:0]             TX_DATA;
  logic                    TX_VLD;
  logic                    TX_RDY = 1'b0;
  logic [7:0]              LED;
  logic [NUM_REGS*32-1:0]  REGS;
  logic                    BUSY;
  logic                    OVERRUN;

  spi_cmd_ctrl #(.NUM_REGS(NUM_REGS), .LED_RESET(LED_RESET)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
    .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_RDY(TX_RDY),
    .LED(LED), .REGS(REGS), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] sb[$];

  // reference state
  logic [7:0]  led_m;
  logic [7:0]  seq_m;
  logic [31:0] regs_m [NUM_REGS];
  logic        ovr_m;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] xsum(input logic [63:0] f);
    return f[63:56] ^ f[55:48] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
  endfunction

  function automatic logic [63:0] with_chk(input logic [63:0] f);
    return {f[63:48], xsum(f), f[39:0]};
  endfunction

  function automatic logic [NUM_REGS*32-1:0] regs_flat();
    logic [NUM_REGS*32-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i*32 +: 32] = regs_m[i];
    return v;
  endfunction

  task automatic model_reset();
    led_m = LED_RESET;
    seq_m = 8'h00;
    ovr_m = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs_m[i] = '0;
  endtask

  // Executes one accepted frame against the reference state.
  task automatic model(input logic [63:0] f, output logic [63:0] r);
    logic [7:0]  op, a, st;
    logic [31:0] d, rd;
    op = f[63:56]; a = f[55:48]; d = f[31:0];
    st = 8'h00;
`ifdef SPI_CMD_CTRL_CHECKSUM_EN
    if (f[47:40] != xsum(f)) st = 8'hE2;
    else
`endif
    if (op > 8'h04) st = 8'hE0;
    else if ((op == 8'h02 || op == 8'h03) && int'(a) >= NUM_REGS) st = 8'hE1;
    seq_m = seq_m + 8'd1;
    rd = 32'h0;
    if (st == 8'h00) begin
      if (op == 8'h01) begin led_m = d[7:0]; rd = d; end
      if (op == 8'h02) begin regs_m[a] = d; rd = d; end
      if (op == 8'h03) rd = regs_m[a];
      if (op == 8'h04) begin rd = {31'h0, ovr_m}; ovr_m = 1'b0; end
    end
    r = {op, a, st, seq_m, rd};
  endtask

  function automatic logic [63:0] rand_frame();
    logic [7:0]  op, a;
    logic [31:0] d;
    logic [63:0] f;
    case ($urandom_range(0, 6))
      0: op = 8'h00;
      1: op = 8'h01;
      2, 3: op = 8'h02;
      4: op = 8'h03;
      5: op = 8'h04;
      default: op = 8'($urandom_range(5, 255));
    endcase
    if ($urandom_range(0, 7) == 0) a = 8'($urandom);
    else a = 8'($urandom_range(0, NUM_REGS));
    d = $urandom;
    if (op == 8'h01) d[31:8] = '0;
    f = {op, a, 8'($urandom), 8'($urandom), d};
`ifdef SPI_CMD_CTRL_CHECKSUM_EN
    f = with_chk(f);
    if ($urandom_range(0, 7) == 0) f[40 + $urandom_range(0, 7)] ^= 1'b1;
`endif
    return f;
  endfunction

  // Sends one frame. inj_ph: extra RX_VLD during DECODE (1) or EXEC (2);
  // inj_hold: extra RX_VLD while TX_RDY is held low; inj_done: RX_VLD on the
  // handshake cycle.
  task automatic send(input logic [63:0] f, input int hold, input int inj_ph,
                      input bit inj_hold, input bit inj_done);
    logic [63:0] r;
    int t;
    if (inj_ph == 1) ovr_m = 1'b1;
    model(f, r);
    if (inj_ph == 2) ovr_m = 1'b1;
    if (inj_hold && hold > 0) ovr_m = 1'b1;
    if (inj_done) ovr_m = 1'b1;
    sb.push_back(r);
    RX_DATA = f; RX_VLD = 1'b1;
    @(posedge CLK); #1;
    RX_VLD = (inj_ph == 1); RX_DATA = {$urandom, $urandom};
    @(posedge CLK); #1;
    RX_VLD = (inj_ph == 2); RX_DATA = {$urandom, $urandom};
    @(posedge CLK); #1;
    RX_VLD = 1'b0;
    chk("tx_vld_rise", TX_VLD, 1'b1);
    t = 0;
    while (!TX_VLD && t < 20) begin @(posedge CLK); #1; t++; end
    for (int k = 0; k < hold; k++) begin
      RX_VLD = inj_hold && (k == hold / 2);
      RX_DATA = {$urandom, $urandom};
      @(posedge CLK); #1;
    end
    RX_VLD = inj_done; TX_RDY = 1'b1;
    @(posedge CLK); #1;
    TX_RDY = 1'b0; RX_VLD = 1'b0;
    chk("busy_after", BUSY, 1'b0);
    chk("led", LED, led_m);
    chk("regs", REGS, regs_flat());
    chk("overrun", OVERRUN, ovr_m);
  endtask

  // Response monitor: compares on handshake and checks hold stability.
  initial begin : mon
    logic        pv;
    logic [63:0] pd;
    logic [63:0] exp_r;
    pv = 1'b0; pd = '0;
    forever begin
      @(negedge CLK);
      if (RST) pv = 1'b0;
      else begin
        if (pv && TX_VLD) chk("tx_stable", TX_DATA, pd);
        if (TX_VLD && TX_RDY) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL resp_unexpected: got %h expected none", TX_DATA);
          end else begin
            exp_r = sb.pop_front();
            chk("resp", TX_DATA, exp_r);
          end
        end
        pv = TX_VLD && !TX_RDY;
        pd = TX_DATA;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_tx_data", TX_DATA, 64'h0);
    chk("rst_tx_vld", TX_VLD, 1'b0);
    chk("rst_led", LED, LED_RESET);
    chk("rst_regs", REGS, '0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_overrun", OVERRUN, 1'b0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // LED write; expected response 01_00_00_01_000000A5
    send(with_chk(64'h01_00_00_00_000000A5), 0, 0, 0, 0);
    // register write then read back
    send(with_chk(64'h02_02_00_00_DEADBEEF), 1, 0, 0, 0);
    send(with_chk(64'h03_02_00_00_00000000), 0, 0, 0, 0);
    chk("reg2", REGS[95:64], 32'hDEADBEEF);
    // out-of-range address and unknown opcode
    send(with_chk(64'h03_04_00_00_12345678), 0, 0, 0, 0);
    send(with_chk(64'h02_04_00_00_12345678), 0, 0, 0, 0);
    send(with_chk(64'h7F_01_00_00_12345678), 0, 0, 0, 0);
    // long stall with a dropped frame, then status read clears the flag
    send(with_chk(64'h00_00_00_00_00000000), 20, 0, 1, 0);
    send(with_chk(64'h04_00_00_00_00000000), 0, 0, 0, 0);
    // overruns in DECODE, EXEC and on the handshake cycle around STAT_RD
    send(with_chk(64'h04_00_00_00_00000000), 0, 1, 0, 0);
    send(with_chk(64'h04_00_00_00_00000000), 0, 2, 0, 0);
    send(with_chk(64'h04_00_00_00_00000000), 0, 0, 0, 1);
    send(with_chk(64'h04_00_00_00_00000000), 0, 0, 0, 0);

    // back-to-back NOPs carry SEQ through its wrap
    for (int i = 0; i < 256; i++) send(with_chk(64'h0), 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      send(rand_frame(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
           ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    // reset while a response is pending
    RX_DATA = with_chk(64'h01_00_00_00_0000005A); RX_VLD = 1'b1;
    @(posedge CLK); #1;
    RX_VLD = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("pre_rst_tx_vld", TX_VLD, 1'b1);
    chk("pre_rst_led", LED, 8'h5A);
    RST = 1'b1;
    #1;
    chk("mid_rst_tx_vld", TX_VLD, 1'b0);
    chk("mid_rst_tx_data", TX_DATA, 64'h0);
    chk("mid_rst_led", LED, LED_RESET);
    chk("mid_rst_regs", REGS, '0);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_overrun", OVERRUN, 1'b0);
    model_reset();
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    send(with_chk(64'h00_00_00_00_00000000), 0, 0, 0, 0);

`ifdef SPI_CMD_CTRL_CHECKSUM_EN
    // correct check byte executes, a single flipped bit is rejected
    send(with_chk(64'h01_00_00_00_00000011), 0, 0, 0, 0);
    send(with_chk(64'h01_00_00_00_00000022) ^ 64'h0000_0400_0000_0000, 0, 0, 0, 0);
    chk("chk_led_kept", LED, 8'h11);
`endif

    t = 0;
    while (sb.size() != 0 && t < 100) begin @(posedge CLK); t++; end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain: got %0d pending responses expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
